// File: rtl/adc_sequencer_pkg.sv
// adc_seq_pkg: shared types and constants for the ADC frame sequencer.
//   - seq_state_e  : sequencer FSM states
//   - ADC_W, CH_W  : ADC result width and channel-select width
//   - AUDIO_OFFSET : offset-binary midpoint, XORed in to get a signed sample
//   - pot_iir()    : first-order smoothing step used when POT_SMOOTH_EN is defined
package adc_seq_pkg;

  localparam int ADC_W = 12;
  localparam int CH_W  = 3;
  localparam logic [ADC_W-1:0] AUDIO_OFFSET = 12'h800;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_AUD = 3'd1,
    ST_WAIT_AUD  = 3'd2,
    ST_START_POT = 3'd3,
    ST_WAIT_POT  = 3'd4
  } seq_state_e;

  // slot + (sample - slot) >>> 2, with a 13-bit signed difference and the sum
  // truncated back to 12 bits.
  function automatic logic [ADC_W-1:0] pot_iir(input logic [ADC_W-1:0] slot,
                                               input logic [ADC_W-1:0] sample);
    logic signed [ADC_W:0] diff;
    logic signed [ADC_W:0] step;
    diff = $signed({1'b0, sample}) - $signed({1'b0, slot});
    step = diff >>> 2;
    return ADC_W'({1'b0, slot} + step);
  endfunction

endpackage

// File: rtl/adc_frame_timer.sv
// adc_frame_timer: free-running frame counter 0..SAMPLE_DIV-1.
//   clk        in  : system clock
//   rst        in  : synchronous active-high reset
//   frame_tick out : high in the cycle the counter equals SAMPLE_DIV-1
module adc_frame_timer #(
  parameter int SAMPLE_DIV = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Counter and tick; the tick is registered one count early so it lines up
  // with the counter holding SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (r_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_tick <= (r_cnt == CNT_W'(SAMPLE_DIV - 2));
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer: per-frame scheduler in front of adc_spi. Each frame converts
// the audio channel, then one pot channel (round-robin), and publishes results.
//   clk, rst           : clock, synchronous active-high reset
//   start_cnv, channel : conversion request / channel select to adc_spi
//   result, cnv_complete : conversion result and its one-cycle completion strobe
//   audio_sample/valid : signed audio sample and its update pulse
//   pot_val/pot_valid  : packed pot bank (slot i = bits [12i+11:12i]) and update pulse
//   overrun            : sticky, a frame tick arrived while busy (frame dropped)
//   timeout_err        : sticky, a conversion did not complete within TIMEOUT
// Optional feature macro: POT_SMOOTH_EN (pot slots become first-order IIR filters).
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int SAMPLE_DIV = 1024,
  parameter int AUDIO_CH   = 0,
  parameter int POT_BASE   = 1,
  parameter int NUM_POTS   = 3,
  parameter int TIMEOUT    = 4095
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      start_cnv,
  output logic [CH_W-1:0]           channel,
  input  logic [ADC_W-1:0]          result,
  input  logic                      cnv_complete,
  output logic [ADC_W-1:0]          audio_sample,
  output logic                      audio_valid,
  output logic [ADC_W*NUM_POTS-1:0] pot_val,
  output logic                      pot_valid,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int IDX_W = (NUM_POTS > 1) ? $clog2(NUM_POTS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  seq_state_e              r_state;
  seq_state_e              w_next;
  logic                    w_tick;
  logic                    w_tick_ok;
  logic                    w_aud_done;
  logic                    w_pot_done;
  logic                    w_timeout;
  logic [IDX_W-1:0]        r_idx;
  logic [WD_W-1:0]         r_wdog;
  logic                    r_start_cnv;
  logic [CH_W-1:0]         r_channel;
  logic [ADC_W-1:0]        r_audio;
  logic                    r_audio_valid;
  logic [ADC_W*NUM_POTS-1:0] r_pot_val;
  logic                    r_pot_valid;
  logic                    r_overrun;
  logic                    r_timeout_err;
  logic [ADC_W-1:0]        w_pot_new;

  adc_frame_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (w_tick)
  );

  // Next-state logic; a completion in the expiry cycle wins over the timeout.
  always_comb begin
    w_next     = r_state;
    w_tick_ok  = 1'b0;
    w_aud_done = 1'b0;
    w_pot_done = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_ok = w_tick;
        if (w_tick) begin
          w_next = ST_START_AUD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START_AUD: w_next = ST_WAIT_AUD;
      ST_WAIT_AUD: begin
        if (cnv_complete) begin
          w_aud_done = 1'b1;
          w_next     = ST_START_POT;
        end else if (r_wdog == WD_W'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_WAIT_AUD;
        end
      end
      ST_START_POT: w_next = ST_WAIT_POT;
      ST_WAIT_POT: begin
        if (cnv_complete) begin
          w_pot_done = 1'b1;
          w_tick_ok  = w_tick;
          if (w_tick) begin
            w_next = ST_START_AUD;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (r_wdog == WD_W'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_WAIT_POT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request, channel, watchdog, audio capture, index and sticky flags.
  // The pot request is issued from the registered START_POT state, so it
  // trails the audio completion by two cycles; the audio request is issued
  // from the next-state decode, one cycle after the accepted tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_cnv   <= 1'b0;
      r_channel     <= CH_W'(AUDIO_CH);
      r_wdog        <= '0;
      r_audio       <= '0;
      r_audio_valid <= 1'b0;
      r_pot_valid   <= 1'b0;
      r_idx         <= '0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start_cnv   <= (w_next == ST_START_AUD) || (r_state == ST_START_POT);
      r_audio_valid <= w_aud_done;
      r_pot_valid   <= w_pot_done;
      if (w_next == ST_START_AUD) begin
        r_channel <= CH_W'(AUDIO_CH);
      end else if (w_next == ST_START_POT) begin
        r_channel <= CH_W'(POT_BASE) + CH_W'(r_idx);
      end
      // Every WAIT state is entered from a START state, so clearing there
      // starts each wait at zero.
      if ((r_state == ST_START_AUD) || (r_state == ST_START_POT)) begin
        r_wdog <= '0;
      end else if (((r_state == ST_WAIT_AUD) || (r_state == ST_WAIT_POT)) &&
                   (r_wdog != WD_W'(TIMEOUT))) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if (w_aud_done) begin
        r_audio <= result ^ AUDIO_OFFSET;
      end
      if (w_pot_done) begin
        if (r_idx == IDX_W'(NUM_POTS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (w_tick && !w_tick_ok) begin
        r_overrun <= 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef POT_SMOOTH_EN
  logic [NUM_POTS-1:0] r_loaded;
  logic [ADC_W-1:0]    w_pot_cur;

  // Current contents of the slot being written.
  always_comb begin
    w_pot_cur = '0;
    for (int i = 0; i < NUM_POTS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pot_cur = r_pot_val[i*ADC_W +: ADC_W];
      end
    end
  end

  // Per-slot flag so the first write after reset loads the sample directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loaded <= '0;
    end else if (w_pot_done) begin
      r_loaded[r_idx] <= 1'b1;
    end
  end

  assign w_pot_new = r_loaded[r_idx] ? pot_iir(w_pot_cur, result) : result;
`else
  assign w_pot_new = result;
`endif

  // Pot bank write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pot_val <= '0;
    end else begin
      for (int i = 0; i < NUM_POTS; i++) begin
        if (w_pot_done && (r_idx == IDX_W'(i))) begin
          r_pot_val[i*ADC_W +: ADC_W] <= w_pot_new;
        end
      end
    end
  end

  assign start_cnv    = r_start_cnv;
  assign channel      = r_channel;
  assign audio_sample = r_audio;
  assign audio_valid  = r_audio_valid;
  assign pot_val      = r_pot_val;
  assign pot_valid    = r_pot_valid;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: a behavioural ADC model answers each
// start_cnv after a programmable latency; expected channels, audio samples and
// pot writes are queued by the stimulus and popped by an independent monitor.
module tb_adc_sequencer;

  localparam int SAMPLE_DIV = 64;
  localparam int TIMEOUT    = 100;
  localparam int NUM_POTS   = 3;
  localparam int AUDIO_CH   = 0;
  localparam int POT_BASE   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_cnv;
  logic [2:0]  channel;
  logic [11:0] result = 12'h000;
  logic        cnv_complete = 1'b0;
  logic [11:0] audio_sample;
  logic        audio_valid;
  logic [35:0] pot_val;
  logic        pot_valid;
  logic        overrun;
  logic        timeout_err;

  always #5 clk = ~clk;

  adc_sequencer #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .AUDIO_CH   (AUDIO_CH),
    .POT_BASE   (POT_BASE),
    .NUM_POTS   (NUM_POTS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_cnv    (start_cnv),
    .channel      (channel),
    .result       (result),
    .cnv_complete (cnv_complete),
    .audio_sample (audio_sample),
    .audio_valid  (audio_valid),
    .pot_val      (pot_val),
    .pot_valid    (pot_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    int          slot;
    logic [11:0] val;
  } pot_exp_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rel = 0;
  logic [11:0] tbl [0:7];
  int          lat = 20;
  int          dead_ch = -1;
  bit          keep_pending = 1'b0;
  int          m_cnt = 0;
  int          m_ch = 0;
  int          m_idx = 0;
  int          m_slot [0:2];
  bit          m_loaded [0:2];

  logic [2:0]  exp_ch_q [$];
  logic [11:0] exp_aud_q [$];
  pot_exp_t    exp_pot_q [$];
  int          st_cyc_q [$];
  int          av_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - rel);
    end
  endtask

  // ADC model: answers latency cycles after the sampled start_cnv.
  initial begin
    forever begin
      @(negedge clk);
      cnv_complete = 1'b0;
      if (rst && !keep_pending) m_cnt = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && m_ch != dead_ch) begin
          cnv_complete = 1'b1;
          result = tbl[m_ch];
        end
      end
      if (start_cnv) begin
        m_cnt = lat;
        m_ch  = int'(channel);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    pot_exp_t e;
    forever begin
      @(negedge clk);
      if (start_cnv) begin
        st_cyc_q.push_back(cyc);
        chk("start_expected", longint'(exp_ch_q.size() > 0), 1);
        if (exp_ch_q.size() > 0) chk("channel", channel, exp_ch_q.pop_front());
      end
      if (audio_valid) begin
        av_cyc_q.push_back(cyc);
        chk("audio_expected", longint'(exp_aud_q.size() > 0), 1);
        if (exp_aud_q.size() > 0) chk("audio_sample", audio_sample, exp_aud_q.pop_front());
      end
      if (pot_valid) begin
        chk("pot_expected", longint'(exp_pot_q.size() > 0), 1);
        if (exp_pot_q.size() > 0) begin
          e = exp_pot_q.pop_front();
          chk("pot_slot_val", pot_val[e.slot*12 +: 12], e.val);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    st_cyc_q.delete();
    av_cyc_q.delete();
    m_idx = 0;
    for (int i = 0; i < 3; i++) begin
      m_slot[i] = 0;
      m_loaded[i] = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_cnv"}, start_cnv, 0);
    chk({tag, "_channel"}, channel, AUDIO_CH);
    chk({tag, "_audio_sample"}, audio_sample, 0);
    chk({tag, "_audio_valid"}, audio_valid, 0);
    chk({tag, "_pot_val"}, pot_val, 0);
    chk({tag, "_pot_valid"}, pot_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Queue the expectations for n complete frames with the current table.
  task automatic plan(input int nframes);
    pot_exp_t e;
    int raw;
    int v;
    for (int f = 0; f < nframes; f++) begin
      exp_ch_q.push_back(3'(AUDIO_CH));
      exp_aud_q.push_back(tbl[AUDIO_CH] ^ 12'h800);
      exp_ch_q.push_back(3'(POT_BASE + m_idx));
      raw = int'(tbl[POT_BASE + m_idx]);
      v = raw;
`ifdef POT_SMOOTH_EN
      if (m_loaded[m_idx]) v = (m_slot[m_idx] + ((raw - m_slot[m_idx]) >>> 2)) & 32'hFFF;
`endif
      m_slot[m_idx] = v;
      m_loaded[m_idx] = 1'b1;
      e.slot = m_idx;
      e.val = 12'(v);
      exp_pot_q.push_back(e);
      m_idx = (m_idx + 1) % NUM_POTS;
    end
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_ch_left"}, exp_ch_q.size(), 0);
    chk({tag, "_aud_left"}, exp_aud_q.size(), 0);
    chk({tag, "_pot_left"}, exp_pot_q.size(), 0);
    exp_ch_q.delete();
    exp_aud_q.delete();
    exp_pot_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = 12'hFFF; tbl[1] = 12'h456; tbl[2] = 12'h123; tbl[3] = 12'h789;
    for (int i = 4; i < 8; i++) tbl[i] = 12'h000;

    // Basic round-robin, full-scale positive audio, timing of first events.
    do_reset();
    chk_reset_vals("rst");
    plan(3);
    wait_cyc(rel + 250);
    chk("s1_n_starts", st_cyc_q.size(), 6);
    if (st_cyc_q.size() >= 2) begin
      chk("s1_aud_start_cyc", st_cyc_q[0] - rel, 64);
      chk("s1_pot_start_cyc", st_cyc_q[1] - rel, 86);
    end
    if (av_cyc_q.size() >= 1) chk("s1_audio_valid_cyc", av_cyc_q[0] - rel, 85);
    chk("s1_pot_bank", pot_val, {12'h789, 12'h123, 12'h456});
    chk("s1_overrun", overrun, 0);
    chk("s1_timeout", timeout_err, 0);
    chk_drained("s1");

    // Full-scale negative audio; one audio pulse per frame.
    tbl[0] = 12'h000;
    do_reset();
    plan(3);
    wait_cyc(rel + 250);
    chk("s2_n_audio", av_cyc_q.size(), 3);
    if (av_cyc_q.size() == 3) begin
      chk("s2_period_a", av_cyc_q[1] - av_cyc_q[0], 64);
      chk("s2_period_b", av_cyc_q[2] - av_cyc_q[1], 64);
    end
    chk("s2_overrun", overrun, 0);
    chk_drained("s2");

    // Slow ADC: a frame no longer fits, every other tick is dropped.
    tbl[0] = 12'h9AB;
    lat = 40;
    do_reset();
    plan(2);
    wait_cyc(rel + 300);
    chk("s3_n_audio", av_cyc_q.size(), 2);
    if (av_cyc_q.size() == 2) chk("s3_period", av_cyc_q[1] - av_cyc_q[0], 128);
    chk("s3_overrun", overrun, 1);
    chk("s3_timeout", timeout_err, 0);
    chk_drained("s3");

    // Pot channel 1 never answers: timeout, idx held, channel 1 retried.
    tbl[0] = 12'hFFF;
    lat = 20;
    dead_ch = 1;
    do_reset();
    exp_ch_q.push_back(3'd0); exp_aud_q.push_back(12'h7FF); exp_ch_q.push_back(3'd1);
    exp_ch_q.push_back(3'd0); exp_aud_q.push_back(12'h7FF); exp_ch_q.push_back(3'd1);
    wait_cyc(rel + 186);
    chk("s4_timeout_early", timeout_err, 0);
    wait_cyc(rel + 187);
    chk("s4_timeout_set", timeout_err, 1);
    wait_cyc(rel + 250);
    chk("s4_pot_bank", pot_val, 0);
    chk("s4_overrun", overrun, 1);
    chk_drained("s4");
    dead_ch = -1;

    // Reset during WAIT_AUD; the abandoned conversion completes afterwards.
    do_reset();
    exp_ch_q.push_back(3'd0);
    wait_cyc(rel + 79);
    keep_pending = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(rel + 100);
    keep_pending = 1'b0;
    chk_reset_vals("s5");
    chk("s5_n_audio", av_cyc_q.size(), 0);
    chk_drained("s5");

    // Pot slot 0 loads 0, then tracks a constant 12'h400.
    tbl[1] = 12'h000;
    do_reset();
    plan(1);
    wait_cyc(rel + 110);
    tbl[1] = 12'h400;
    plan(9);
    wait_cyc(rel + 690);
`ifdef POT_SMOOTH_EN
    chk("s6_slot0_final", pot_val[11:0], 12'd592);
`else
    chk("s6_slot0_final", pot_val[11:0], 12'h400);
`endif
    chk_drained("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Frame-rate conversion scheduler sitting directly upstream of `adc_spi`. Each audio frame it requests one conversion of the audio input channel and one conversion of a potentiometer channel (round-robin), drives `adc_spi`'s `start_cnv`/`channel` inputs, and captures `result` on `cnv_complete`. It publishes a signed audio sample stream to the effects chain and a bank of pot values to the parameter logic, and flags frame overruns and stalled conversions.

## Interface
- `SAMPLE_DIV`, 1024: clocks per audio frame; must be ≥ 2.
- `AUDIO_CH`, 0: ADC channel carrying audio.
- `POT_BASE`, 1: first pot channel.
- `NUM_POTS`, 3: number of pot channels, from 1 to 7. Pots occupy `POT_BASE`..`POT_BASE+NUM_POTS-1`.
- `TIMEOUT`, 4095: maximum cycles to wait for `cnv_complete`.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous reset, active-high.
- `start_cnv` out 1: one-cycle conversion request to `adc_spi`.
- `channel` out 3: channel select to `adc_spi`.
- `result` in 12: `adc_spi` conversion result, unsigned offset-binary.
- `cnv_complete` in 1: one-cycle pulse; `result` is valid in the same cycle.
- `audio_sample` out 12: signed audio sample.
- `audio_valid` out 1: one-cycle pulse when a new `audio_sample` is available.
- `pot_val` out 12*NUM_POTS: packed pot values; slot i is bits [12i+11:12i].
- `pot_valid` out 1: one-cycle pulse when any pot slot updates.
- `overrun` out 1: sticky; a frame tick arrived while the sequencer was busy.
- `timeout_err` out 1: sticky; a conversion exceeded `TIMEOUT`.

## Operation
- Frame counter runs 0..`SAMPLE_DIV`-1 and wraps. `frame_tick` is asserted in the cycle the counter equals `SAMPLE_DIV`-1.
- FSM states: IDLE, START_AUD, WAIT_AUD, START_POT, WAIT_POT.
  - IDLE: on an accepted tick, go to START_AUD.
  - START_AUD: assert `start_cnv`, drive `channel`=`AUDIO_CH`, go to WAIT_AUD.
  - WAIT_AUD: on `cnv_complete`, capture the audio value and go to START_POT.
  - START_POT: assert `start_cnv`, drive `channel`=`POT_BASE`+idx, go to WAIT_POT.
  - WAIT_POT: on `cnv_complete`, write pot slot idx, advance idx modulo `NUM_POTS`, go to IDLE.
- Audio conversion: `audio_sample` = `result` XOR 12'h800, i.e. 12'h800 maps to 0, 12'hFFF to +2047, 12'h000 to -2048.
- Tick acceptance: a tick is accepted in IDLE, and also in WAIT_POT in the same cycle as `cnv_complete` (the next state is then START_AUD). Any other tick sets `overrun` and that frame is dropped; the in-flight sequence continues.
- Watchdog: a counter is cleared on entry to each WAIT state.
  - When it reaches `TIMEOUT` without `cnv_complete`: set `timeout_err`, return to IDLE, produce no valid pulse, and leave idx unchanged.
  - `cnv_complete` in the same cycle as expiry counts as completion, not a timeout.
- `cnv_complete` received in IDLE or a START state is ignored.
- Sticky flags clear only on `rst`.

## Timing
- Reset values:
  - `start_cnv`=0, `channel`=`AUDIO_CH`, `audio_sample`=0, `audio_valid`=0.
  - `pot_val`=0, `pot_valid`=0, `overrun`=0, `timeout_err`=0.
  - Frame counter=0, idx=0, state IDLE.
- `rst` asserted mid-conversion returns to IDLE at the next edge. A later `cnv_complete` from the abandoned conversion is ignored.
- `start_cnv` goes high 1 cycle after the accepted tick cycle.
- `channel` is registered. It is valid in the `start_cnv` cycle and held until the next START state.
- `audio_valid` and `pot_valid` are asserted 1 cycle after `cnv_complete`, with data registered in that same cycle.
- Pot `start_cnv` is asserted 2 cycles after the audio `cnv_complete`.

## Configuration
- `POT_SMOOTH_EN` defined: each pot slot is a first-order IIR, slot += (result − slot) >>> 2.
  - The difference is computed as 13-bit signed; the sum is truncated back to 12 bits unsigned.
  - The first write after reset loads `result` directly.
- `POT_SMOOTH_EN` undefined: the slot is loaded directly with `result`.
- The audio path is unaffected either way.

## Structure
- Package `adc_seq_pkg` holds:
  - the FSM state enum;
  - `ADC_W`=12, `CH_W`=3;
  - `AUDIO_OFFSET`=12'h800.
- Sub-module `adc_frame_timer`: parameter `SAMPLE_DIV`, inputs `clk` and `rst`, output `frame_tick`.

## Test plan
- All cases use a bench ADC model that pulses `cnv_complete` 20 cycles after `start_cnv`, with `SAMPLE_DIV`=64, `TIMEOUT`=100, `NUM_POTS`=3.
- Model returns 12'hFFF for ch0 and 12'h123 for ch2 → `audio_sample`=+2047 (12'h7FF); after 3 frames the channel sequence is 0,1,0,2,0,3, with the slot 1 value 12'h123 (without `POT_SMOOTH_EN`).
- Model returns 12'h000 for ch0 → `audio_sample`=12'h800 (−2048); `audio_valid` pulses exactly once per 64 cycles.
- Model latency raised to 40 cycles (frame needs more than 64) → `overrun`=1 and `audio_valid` occurs every 128 cycles.
- Model never completes ch1 → `timeout_err`=1 at 100 cycles; the next frame converts ch0 then ch1 again (idx unchanged).
- `rst` asserted while in WAIT_AUD, model completes 5 cycles later → no `audio_valid`, all outputs at reset values.
- `POT_SMOOTH_EN` defined, ch1 at constant 12'h400 after the first load of 0 → slot 0 takes 0, then 256, 448, 592 on successive writes.
